ex_stage_ctrl: RTL and testbench
================================

Name: ex_stage_ctrl

Overview:
- Execute-stage controller: the requester side of the ALU interface.
- Registers decoded operations from ID and drives the ALU operand/op bus combinationally from its input register.
- Captures the ALU result and overflow flag, and presents a registered EX/MEM payload.
- Converts signed overflow into a precise exception: writeback is suppressed, and the stage holds until the trap is acknowledged.

Parameters:
- DAT_WIDTH, 32, operand/result width.
- OP_BUS, 4, ALU op code width; encodings are the `ALU_OP_*` codes in cpu.h.
- REG_ADDR_W, 5, register-file address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid_i  input  1  ID payload valid.
- id_ready_o  output  1  stage can accept an ID payload this cycle.
- id_op_i  input  OP_BUS  ALU op code.
- id_src0_i  input  DAT_WIDTH  operand 0.
- id_src1_i  input  DAT_WIDTH  operand 1.
- id_rs0_i  input  REG_ADDR_W  source register of operand 0 (used only with EX_FWD_EN).
- id_rs1_i  input  REG_ADDR_W  source register of operand 1 (used only with EX_FWD_EN).
- id_dst_i  input  REG_ADDR_W  destination register.
- id_wr_en_i  input  1  instruction writes a register.
- id_pc_i  input  DAT_WIDTH  instruction PC.
- alu_op_o  output  OP_BUS  op to ALU.
- alu_in_0_o  output  DAT_WIDTH  ALU operand 0.
- alu_in_1_o  output  DAT_WIDTH  ALU operand 1.
- alu_out_i  input  DAT_WIDTH  ALU result.
- alu_of_i  input  1  ALU overflow flag.
- mem_ready_i  input  1  downstream accepts the EX payload.
- ex_valid_o  output  1  EX payload valid.
- ex_result_o  output  DAT_WIDTH  registered result.
- ex_dst_o  output  REG_ADDR_W  registered destination.
- ex_wr_en_o  output  1  registered write enable; forced 0 on overflow.
- exc_ovf_o  output  1  overflow trap request, level.
- exc_pc_o  output  DAT_WIDTH  PC of the faulting instruction.
- exc_ack_i  input  1  trap accepted by control unit.
- flush_i  input  1  squash all in-flight state.

Behaviour:
- Reset (async, rst_n=0): every output register is 0.
  - ex_valid_o=0, ex_result_o=0, ex_dst_o=0, ex_wr_en_o=0, exc_ovf_o=0, exc_pc_o=0.
  - Input register is invalid; FSM is in RUN.
- Input register (IR): loads ID fields when id_valid_i && id_ready_o.
- ALU bus: alu_op_o, alu_in_0_o and alu_in_1_o come combinationally from IR.
  - With IR invalid, alu_op_o = 0 and both operands = 0.
- Two-stage handshake:
  - IR -> output register when the output register is empty or mem_ready_i=1, and FSM=RUN.
  - id_ready_o = FSM==RUN && (IR empty || IR advances this cycle).
- Latency: a payload accepted at edge N appears on ex_valid_o after edge N+1.
  - Throughput is 1 per cycle with mem_ready_i=1.
- Backpressure: with ex_valid_o=1 and mem_ready_i=0, all EX outputs are held stable and IR holds.
- FSM RUN:
  - On IR advance with alu_of_i=1: output register loads result, dst and PC; ex_wr_en_o=0; exc_ovf_o=1; exc_pc_o=IR PC.
  - FSM then moves to TRAP.
- FSM TRAP:
  - id_ready_o=0; IR is not loaded.
  - exc_ovf_o and exc_pc_o are held.
  - On exc_ack_i=1: exc_ovf_o=0, ex_valid_o=0, FSM returns to RUN on the next cycle.
  - Any instruction still in IR is discarded on that same edge, because instructions after a trap must not commit.
- alu_of_i is only acted on for ADDS/SUBS; for all other op codes it is ignored.
- flush_i (synchronous, highest priority after reset):
  - IR and output register become invalid; ex_wr_en_o=0; exc_ovf_o=0; FSM returns to RUN.
  - flush_i with exc_ack_i in the same cycle gives the same result as flush_i alone.
- Simultaneous accept and output drain in the same cycle is allowed; there is no bubble.
- Widths: result is passed through unmodified at DAT_WIDTH; there is no carry-out.

Optional Feature:
- Macro: EX_FWD_EN.
- Defined: the EX->EX bypass is enabled.
  - If the output register is valid, ex_wr_en_o=1, ex_dst_o != 0 and ex_dst_o == IR rs0, then alu_in_0_o = ex_result_o.
  - The same rule applies for rs1 and alu_in_1_o.
  - A bypass from an overflowed result never occurs, because ex_wr_en_o=0 in that case.
- Undefined: operands always come from IR; the rs0/rs1 ports are unused.

Test Plan:
- Reset mid-stream: ADDU 3+4 issued, rst_n pulsed low between edges -> all outputs 0 immediately, ex_valid_o=0 after release.
- Streaming: ADDU 5+7 then SUBU 10-3 back-to-back, mem_ready_i=1 -> ex_result_o = 12, then 7 on consecutive cycles with ex_wr_en_o=1.
- Backpressure: mem_ready_i=0 for 3 cycles holding XOR 0xF0F0^0x0FF0 -> ex_result_o=0xFF00 held stable; id_ready_o=0 once IR is full.
- Overflow: ADDS 0x7FFFFFFF+1, pc=0x100 -> exc_ovf_o=1, exc_pc_o=0x100, ex_wr_en_o=0.
  - The next instruction is blocked; exc_ack_i clears the trap one cycle later.
- Flush: flush_i during TRAP with an instruction held in IR -> exc_ovf_o=0, ex_valid_o=0, RUN; the IR instruction is never output.
- EX_FWD_EN: ADDU r3=2+3, then ADDU r4=r3+1 with stale src0=0 -> second result is 6; with the macro undefined the second result is 1.

Source files
------------

// File: rtl/ex_stage_ctrl_if.sv
// ---------------------------------------------------------------------------
// ex_stage_ctrl_if
// Operand/op bus between the execute-stage controller (requester) and the ALU.
//   alu_op    requester -> ALU  op code
//   alu_in_0  requester -> ALU  operand 0
//   alu_in_1  requester -> ALU  operand 1
//   alu_out   ALU -> requester  result
//   alu_of    ALU -> requester  signed overflow flag
// Modports: master = execute-stage controller, slave = ALU.
// ---------------------------------------------------------------------------
interface ex_stage_ctrl_if #(
  parameter int DAT_WIDTH = 32,
  parameter int OP_BUS    = 4
);
  logic [OP_BUS-1:0]    alu_op;
  logic [DAT_WIDTH-1:0] alu_in_0;
  logic [DAT_WIDTH-1:0] alu_in_1;
  logic [DAT_WIDTH-1:0] alu_out;
  logic                 alu_of;

  modport master (
    output alu_op, alu_in_0, alu_in_1,
    input  alu_out, alu_of
  );

  modport slave (
    input  alu_op, alu_in_0, alu_in_1,
    output alu_out, alu_of
  );
endinterface

// File: rtl/ex_stage_ctrl.sv
// ---------------------------------------------------------------------------
// ex_stage_ctrl
// Execute-stage controller. An input register (IR) captures decoded ops from
// ID and drives the ALU bus combinationally; the ALU result is captured into
// a registered EX/MEM payload. Signed overflow on ADDS/SUBS becomes a precise
// trap: writeback is suppressed and the stage stalls until exc_ack_i.
//
// Optional feature: define EX_FWD_EN to enable the EX->EX operand bypass
// (uses id_rs0_i/id_rs1_i). Without it the rs ports are unused.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   id_valid_i / id_ready_o    ID handshake
//   id_op_i, id_src0_i, id_src1_i, id_rs0_i, id_rs1_i,
//   id_dst_i, id_wr_en_i, id_pc_i         decoded instruction fields
//   alu                        ALU bus (master side of ex_stage_ctrl_if)
//   mem_ready_i                downstream accepts EX payload
//   ex_valid_o, ex_result_o, ex_dst_o, ex_wr_en_o   registered EX payload
//   exc_ovf_o, exc_pc_o, exc_ack_i                  overflow trap handshake
//   flush_i                    squash all in-flight state
// ---------------------------------------------------------------------------
module ex_stage_ctrl #(
  parameter int DAT_WIDTH  = 32,
  parameter int OP_BUS     = 4,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid_i,
  output logic                  id_ready_o,
  input  logic [OP_BUS-1:0]     id_op_i,
  input  logic [DAT_WIDTH-1:0]  id_src0_i,
  input  logic [DAT_WIDTH-1:0]  id_src1_i,
  input  logic [REG_ADDR_W-1:0] id_rs0_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_dst_i,
  input  logic                  id_wr_en_i,
  input  logic [DAT_WIDTH-1:0]  id_pc_i,
  ex_stage_ctrl_if.master       alu,
  input  logic                  mem_ready_i,
  output logic                  ex_valid_o,
  output logic [DAT_WIDTH-1:0]  ex_result_o,
  output logic [REG_ADDR_W-1:0] ex_dst_o,
  output logic                  ex_wr_en_o,
  output logic                  exc_ovf_o,
  output logic [DAT_WIDTH-1:0]  exc_pc_o,
  input  logic                  exc_ack_i,
  input  logic                  flush_i
);

  // Only the signed add/sub codes raise traps.
  localparam logic [OP_BUS-1:0] ALU_OP_ADDS = OP_BUS'(2);
  localparam logic [OP_BUS-1:0] ALU_OP_SUBS = OP_BUS'(3);

  typedef enum logic {ST_RUN = 1'b0, ST_TRAP = 1'b1} state_e;
  state_e state_q, state_d;

  // IR (stage 0)
  logic                  ir_vld_q, ir_vld_d;
  logic [OP_BUS-1:0]     ir_op_q;
  logic [DAT_WIDTH-1:0]  ir_src0_q, ir_src1_q, ir_pc_q;
  logic [REG_ADDR_W-1:0] ir_dst_q;
  logic                  ir_we_q;

  // EX output register (stage 1)
  logic                  ex_vld_q, ex_vld_d;
  logic [DAT_WIDTH-1:0]  ex_res_q, ex_res_d;
  logic [REG_ADDR_W-1:0] ex_dst_q, ex_dst_d;
  logic                  ex_we_q, ex_we_d;
  logic                  exc_ovf_q, exc_ovf_d;
  logic [DAT_WIDTH-1:0]  exc_pc_q, exc_pc_d;

  logic                  advance, accept, trap_hit;
  logic [DAT_WIDTH-1:0]  opnd0, opnd1;

  // Operand selection, optionally bypassing the previous result.
`ifdef EX_FWD_EN
  logic [REG_ADDR_W-1:0] ir_rs0_q, ir_rs1_q;
  logic                  fwd0, fwd1;

  always_ff @(posedge clk) begin
    if (accept) begin
      ir_rs0_q <= id_rs0_i;
      ir_rs1_q <= id_rs1_i;
    end
  end

  // An overflowed result has ex_we_q=0, so it can never be bypassed.
  assign fwd0  = ex_vld_q && ex_we_q && (ex_dst_q != '0) && (ex_dst_q == ir_rs0_q);
  assign fwd1  = ex_vld_q && ex_we_q && (ex_dst_q != '0) && (ex_dst_q == ir_rs1_q);
  assign opnd0 = fwd0 ? ex_res_q : ir_src0_q;
  assign opnd1 = fwd1 ? ex_res_q : ir_src1_q;
`else
  logic unused_rs;
  assign unused_rs = ^{id_rs0_i, id_rs1_i};
  assign opnd0     = ir_src0_q;
  assign opnd1     = ir_src1_q;
`endif

  always_comb begin
    alu.alu_op   = ir_vld_q ? ir_op_q : '0;
    alu.alu_in_0 = ir_vld_q ? opnd0   : '0;
    alu.alu_in_1 = ir_vld_q ? opnd1   : '0;
  end

  // Handshake and FSM next state
  always_comb begin
    state_d    = state_q;
    advance    = ir_vld_q && (!ex_vld_q || mem_ready_i) && (state_q == ST_RUN);
    id_ready_o = (state_q == ST_RUN) && (!ir_vld_q || advance);
    accept     = id_valid_i && id_ready_o;
    trap_hit   = advance && alu.alu_of &&
                 ((ir_op_q == ALU_OP_ADDS) || (ir_op_q == ALU_OP_SUBS));
    if (flush_i) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:  if (trap_hit)  state_d = ST_TRAP;
        ST_TRAP: if (exc_ack_i) state_d = ST_RUN;
        default: state_d = ST_RUN;
      endcase
    end
  end

  // Register next-state. In TRAP the faulting payload is held in the output
  // register regardless of mem_ready_i; it only leaves on ack or flush.
  always_comb begin
    ir_vld_d  = ir_vld_q;
    ex_vld_d  = ex_vld_q;
    ex_res_d  = ex_res_q;
    ex_dst_d  = ex_dst_q;
    ex_we_d   = ex_we_q;
    exc_ovf_d = exc_ovf_q;
    exc_pc_d  = exc_pc_q;
    if (flush_i) begin
      ir_vld_d  = 1'b0;
      ex_vld_d  = 1'b0;
      ex_we_d   = 1'b0;
      exc_ovf_d = 1'b0;
    end else if (state_q == ST_TRAP) begin
      if (exc_ack_i) begin
        // Younger instruction in IR must not commit after the trap.
        ir_vld_d  = 1'b0;
        ex_vld_d  = 1'b0;
        ex_we_d   = 1'b0;
        exc_ovf_d = 1'b0;
      end
    end else begin
      if (advance) begin
        ex_vld_d = 1'b1;
        ex_res_d = alu.alu_out;
        ex_dst_d = ir_dst_q;
        ex_we_d  = ir_we_q && !trap_hit;
        if (trap_hit) begin
          exc_ovf_d = 1'b1;
          exc_pc_d  = ir_pc_q;
        end
      end else if (mem_ready_i) begin
        ex_vld_d = 1'b0;
        ex_we_d  = 1'b0;
      end
      if (accept)       ir_vld_d = 1'b1;
      else if (advance) ir_vld_d = 1'b0;
    end
  end

  // Stage 0: IR payload (data only, validity lives in ir_vld_q)
  always_ff @(posedge clk) begin
    if (accept) begin
      ir_op_q   <= id_op_i;
      ir_src0_q <= id_src0_i;
      ir_src1_q <= id_src1_i;
      ir_dst_q  <= id_dst_i;
      ir_we_q   <= id_wr_en_i;
      ir_pc_q   <= id_pc_i;
    end
  end

  // Stage 1: control state and EX output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      ir_vld_q  <= 1'b0;
      ex_vld_q  <= 1'b0;
      ex_res_q  <= '0;
      ex_dst_q  <= '0;
      ex_we_q   <= 1'b0;
      exc_ovf_q <= 1'b0;
      exc_pc_q  <= '0;
    end else begin
      state_q   <= state_d;
      ir_vld_q  <= ir_vld_d;
      ex_vld_q  <= ex_vld_d;
      ex_res_q  <= ex_res_d;
      ex_dst_q  <= ex_dst_d;
      ex_we_q   <= ex_we_d;
      exc_ovf_q <= exc_ovf_d;
      exc_pc_q  <= exc_pc_d;
    end
  end

  assign ex_valid_o  = ex_vld_q;
  assign ex_result_o = ex_res_q;
  assign ex_dst_o    = ex_dst_q;
  assign ex_wr_en_o  = ex_we_q;
  assign exc_ovf_o   = exc_ovf_q;
  assign exc_pc_o    = exc_pc_q;

endmodule

// File: tb/tb_ex_stage_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ex_stage_ctrl
// Directed bench for ex_stage_ctrl with an ALU stub on the interface, a
// transaction-level model of the stage, a per-cycle compare process and
// hand-computed literal expectations. Honours EX_FWD_EN like the design.
// ---------------------------------------------------------------------------
module tb_ex_stage_ctrl;
  localparam int DW = 32;
  localparam int OB = 4;
  localparam int AW = 5;

  localparam logic [3:0] ADDU = 4'd0;
  localparam logic [3:0] SUBU = 4'd1;
  localparam logic [3:0] ADDS = 4'd2;
  localparam logic [3:0] SUBS = 4'd3;
  localparam logic [3:0] ANDO = 4'd4;
  localparam logic [3:0] ORO  = 4'd5;
  localparam logic [3:0] XORO = 4'd6;

`ifdef EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid, id_ready, id_we;
  logic [OB-1:0] id_op;
  logic [DW-1:0] id_src0, id_src1, id_pc;
  logic [AW-1:0] id_rs0, id_rs1, id_dst;
  logic          mem_ready, ex_valid, ex_wr_en, exc_ovf, exc_ack, flush;
  logic [DW-1:0] ex_result, exc_pc;
  logic [AW-1:0] ex_dst;

  always #5 clk = ~clk;

  ex_stage_ctrl_if #(.DAT_WIDTH(DW), .OP_BUS(OB)) alu_bus ();

  ex_stage_ctrl #(.DAT_WIDTH(DW), .OP_BUS(OB), .REG_ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid), .id_ready_o(id_ready), .id_op_i(id_op),
    .id_src0_i(id_src0), .id_src1_i(id_src1), .id_rs0_i(id_rs0), .id_rs1_i(id_rs1),
    .id_dst_i(id_dst), .id_wr_en_i(id_we), .id_pc_i(id_pc),
    .alu(alu_bus),
    .mem_ready_i(mem_ready), .ex_valid_o(ex_valid), .ex_result_o(ex_result),
    .ex_dst_o(ex_dst), .ex_wr_en_o(ex_wr_en), .exc_ovf_o(exc_ovf), .exc_pc_o(exc_pc),
    .exc_ack_i(exc_ack), .flush_i(flush)
  );

  // ---------------- arithmetic shared by ALU stub and model ----------------
  function automatic logic [DW-1:0] alu_res(input logic [OB-1:0] op,
                                            input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      ADDU, ADDS: return a + b;
      SUBU, SUBS: return a - b;
      ANDO:       return a & b;
      ORO:        return a | b;
      XORO:       return a ^ b;
      default:    return '0;
    endcase
  endfunction

  // Signed overflow of the add/sub family; 0 for everything else.
  function automatic logic sovf(input logic [OB-1:0] op,
                                input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [DW-1:0] sa, sb;
    logic signed [DW:0]   w;
    sa = a;
    sb = b;
    case (op)
      ADDU, ADDS: w = sa + sb;
      SUBU, SUBS: w = sa - sb;
      default:    return 1'b0;
    endcase
    return w[DW] != w[DW-1];
  endfunction

  // ALU stub: also flags overflow for ADDU/SUBU, which the stage must ignore.
  assign alu_bus.alu_out = alu_res(alu_bus.alu_op, alu_bus.alu_in_0, alu_bus.alu_in_1);
  assign alu_bus.alu_of  = sovf(alu_bus.alu_op, alu_bus.alu_in_0, alu_bus.alu_in_1);

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One pending instruction slot, one result slot, a trap flag.
  logic          m_ir_v = 0, m_we = 0, m_ex_v = 0, m_exwe = 0, m_ovf = 0, m_trap = 0;
  logic [OB-1:0] m_op = '0;
  logic [DW-1:0] m_a = '0, m_b = '0, m_pc = '0, m_res = '0, m_epc = '0;
  logic [AW-1:0] m_rs0 = '0, m_rs1 = '0, m_dst = '0, m_exdst = '0;
  logic          m_go, m_rdy, m_of;
  logic [DW-1:0] m_x, m_y;

  function automatic logic [DW-1:0] m_opnd(input logic [DW-1:0] src, input logic [AW-1:0] rs);
    logic hit;
    hit = m_ex_v && m_exwe && (m_exdst != '0) && (m_exdst == rs);
    if (FWD && hit) return m_res;
    return src;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_ir_v = 0; m_ex_v = 0; m_exwe = 0; m_ovf = 0; m_trap = 0;
        m_res = '0; m_exdst = '0; m_epc = '0;
      end else if (flush) begin
        m_ir_v = 0; m_ex_v = 0; m_exwe = 0; m_ovf = 0; m_trap = 0;
      end else if (m_trap) begin
        if (exc_ack) begin
          m_trap = 0; m_ovf = 0; m_ex_v = 0; m_exwe = 0; m_ir_v = 0;
        end
      end else begin
        m_go  = m_ir_v && (!m_ex_v || mem_ready);
        m_rdy = !m_ir_v || m_go;
        if (m_go) begin
          m_x   = m_opnd(m_a, m_rs0);
          m_y   = m_opnd(m_b, m_rs1);
          m_of  = ((m_op == ADDS) || (m_op == SUBS)) && sovf(m_op, m_x, m_y);
          m_res = alu_res(m_op, m_x, m_y);
          m_ex_v = 1; m_exdst = m_dst; m_exwe = m_we && !m_of;
          if (m_of) begin m_ovf = 1; m_epc = m_pc; m_trap = 1; end
          m_ir_v = 0;
        end else if (m_ex_v && mem_ready) begin
          m_ex_v = 0; m_exwe = 0;
        end
        if (id_valid && m_rdy) begin
          m_ir_v = 1; m_op = id_op; m_a = id_src0; m_b = id_src1;
          m_rs0 = id_rs0; m_rs1 = id_rs1; m_dst = id_dst; m_we = id_we; m_pc = id_pc;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("ex_valid", ex_valid, m_ex_v);
        chk("exc_ovf", exc_ovf, m_ovf);
        chk("exc_pc", exc_pc, m_epc);
        chk("id_ready", id_ready, !m_trap && (!m_ir_v || !m_ex_v || mem_ready));
        if (m_ex_v) begin
          chk("ex_result", ex_result, m_res);
          chk("ex_dst", ex_dst, m_exdst);
          chk("ex_wr_en", ex_wr_en, m_exwe);
        end
        chk("alu_op", alu_bus.alu_op, m_ir_v ? m_op : '0);
        chk("alu_in_0", alu_bus.alu_in_0, m_ir_v ? m_opnd(m_a, m_rs0) : '0);
        chk("alu_in_1", alu_bus.alu_in_1, m_ir_v ? m_opnd(m_b, m_rs1) : '0);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_op = '0; id_src0 = '0; id_src1 = '0;
    id_rs0 = '0; id_rs1 = '0; id_dst = '0; id_we = 0; id_pc = '0;
  endtask

  task automatic send(input logic [OB-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [AW-1:0] rs0, input logic [AW-1:0] rs1,
                      input logic [AW-1:0] dst, input logic [DW-1:0] pc);
    id_valid = 1; id_op = op; id_src0 = a; id_src1 = b;
    id_rs0 = rs0; id_rs1 = rs1; id_dst = dst; id_we = 1; id_pc = pc;
  endtask

  initial begin
    idle();
    mem_ready = 1; exc_ack = 0; flush = 0; rst_n = 0;
    repeat (2) cyc();
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_result", ex_result, 0);
    chk("rst_ex_dst", ex_dst, 0);
    chk("rst_ex_wr_en", ex_wr_en, 0);
    chk("rst_exc_ovf", exc_ovf, 0);
    chk("rst_exc_pc", exc_pc, 0);
    chk("rst_alu_op", alu_bus.alu_op, 0);
    rst_n = 1;

    // reset in the middle of a transfer
    send(ADDU, 3, 4, 0, 0, 1, 32'h10); cyc(); idle();
    chk("mid_alu_in_0", alu_bus.alu_in_0, 3);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_ex_valid", ex_valid, 0);
    chk("mid_rst_alu_in_0", alu_bus.alu_in_0, 0);
    chk("mid_rst_ex_result", ex_result, 0);
    #1 rst_n = 1;
    cyc();
    chk("post_rst_ex_valid", ex_valid, 0);

    // streaming
    send(ADDU, 5, 7, 0, 0, 1, 32'h20); cyc();
    send(SUBU, 10, 3, 0, 0, 2, 32'h24); cyc(); idle();
    chk("stream_res0", ex_result, 12);
    chk("stream_we0", ex_wr_en, 1);
    chk("stream_vld0", ex_valid, 1);
    cyc();
    chk("stream_res1", ex_result, 7);
    chk("stream_dst1", ex_dst, 2);
    cyc();
    chk("stream_drain", ex_valid, 0);

    // backpressure
    mem_ready = 0;
    send(XORO, 32'hF0F0, 32'h0FF0, 0, 0, 5, 32'h30); cyc();
    send(ADDU, 1, 1, 0, 0, 6, 32'h34); cyc();
    send(ADDU, 2, 2, 0, 0, 7, 32'h38);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_res", ex_result, 32'hFF00);
      chk("bp_id_ready", id_ready, 0);
      cyc();
    end
    chk("bp_res_after3", ex_result, 32'hFF00);
    mem_ready = 1;
    cyc(); idle();
    chk("bp_res1", ex_result, 2);
    chk("bp_dst1", ex_dst, 6);
    cyc();
    chk("bp_res2", ex_result, 4);
    cyc();

    // unsigned add wraps without a trap
    send(ADDU, 32'h7FFF_FFFF, 1, 0, 0, 9, 32'h40); cyc(); idle(); cyc();
    chk("addu_res", ex_result, 32'h8000_0000);
    chk("addu_we", ex_wr_en, 1);
    chk("addu_no_trap", exc_ovf, 0);
    cyc();

    // signed add overflow -> trap
    send(ADDS, 32'h7FFF_FFFF, 1, 0, 0, 8, 32'h100); cyc();
    send(ADDU, 1, 2, 0, 0, 11, 32'h104); cyc();
    chk("ovf_flag", exc_ovf, 1);
    chk("ovf_pc", exc_pc, 32'h100);
    chk("ovf_we", ex_wr_en, 0);
    chk("ovf_vld", ex_valid, 1);
    chk("ovf_id_ready", id_ready, 0);
    send(ADDU, 9, 9, 0, 0, 10, 32'h108); cyc();
    chk("trap_hold_flag", exc_ovf, 1);
    chk("trap_hold_pc", exc_pc, 32'h100);
    chk("trap_blocked", id_ready, 0);
    exc_ack = 1; cyc(); exc_ack = 0;
    chk("ack_flag", exc_ovf, 0);
    chk("ack_vld", ex_valid, 0);
    chk("ack_ready", id_ready, 1);
    cyc(); idle();
    chk("ack_discard", ex_valid, 0);
    cyc();
    chk("after_trap_res", ex_result, 18);
    chk("after_trap_dst", ex_dst, 10);
    cyc();

    // flush with ack in the same cycle during a SUBS trap, IR occupied
    send(SUBS, 32'h8000_0000, 1, 0, 0, 12, 32'h200); cyc();
    send(ADDU, 5, 5, 0, 0, 13, 32'h204); cyc(); idle();
    chk("subs_flag", exc_ovf, 1);
    chk("subs_pc", exc_pc, 32'h200);
    chk("subs_res", ex_result, 32'h7FFF_FFFF);
    flush = 1; exc_ack = 1; cyc(); flush = 0; exc_ack = 0;
    chk("flush_flag", exc_ovf, 0);
    chk("flush_vld", ex_valid, 0);
    chk("flush_we", ex_wr_en, 0);
    chk("flush_ready", id_ready, 1);
    chk("flush_ir_empty", alu_bus.alu_op, 0);
    cyc();
    chk("flush_no_output", ex_valid, 0);

    // back-to-back dependency through r3
    send(ADDU, 2, 3, 0, 0, 3, 32'h300); cyc();
    send(ADDU, 0, 1, 3, 0, 4, 32'h304); cyc(); idle();
    chk("fwd_res0", ex_result, 5);
    cyc();
    chk("fwd_res1", ex_result, FWD ? 32'd6 : 32'd1);
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
